// File: rtl/hdng_pid_pkg.sv
// Shared types and saturation helpers for the heading-correction PID.
package hdng_pkg;

  typedef logic signed [11:0] hdng_t;
  typedef logic signed [11:0] spd_t;
  typedef logic signed [9:0]  err_t;
  typedef logic signed [6:0]  ddiff_t;

  // Clamp a 12-bit heading difference to the 10-bit error range.
  function automatic err_t sat10(input logic signed [11:0] x);
    if (x > 12'sd511)
      return 10'sd511;
    else if (x < -12'sd512)
      return 10'sh200;
    else
      return err_t'(x);
  endfunction

  // Clamp an 11-bit error difference to the 7-bit derivative range.
  function automatic ddiff_t sat7(input logic signed [10:0] x);
    if (x > 11'sd63)
      return 7'sd63;
    else if (x < -11'sd64)
      return 7'sh40;
    else
      return ddiff_t'(x);
  endfunction

  // Clamp a 14-bit speed sum to the 12-bit motor command range.
  function automatic spd_t sat12(input logic signed [13:0] x);
    if (x > 14'sd2047)
      return 12'sd2047;
    else if (x < -14'sd2048)
      return 12'sh800;
    else
      return spd_t'(x);
  endfunction

endpackage

// File: rtl/hdng_pid_integ.sv
// 16-bit signed error integrator: holds on signed overflow, clears while idle.
module pid_integ
  import hdng_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic signed [9:0]   err,
  output logic signed [15:0]  integ
);

  logic signed [15:0] integ_q;
  logic signed [15:0] integ_d;
  logic signed [15:0] sum;
  logic               ovf;

  assign sum = integ_q + 16'(err);
  // Overflow only possible when both operands share a sign and the result flips it.
  assign ovf = (integ_q[15] == err[9]) && (sum[15] != integ_q[15]);

  // Next integrator value: clear dominates, then accumulate unless overflowing.
  always_comb begin
    integ_d = integ_q;
    if (clr)
      integ_d = '0;
    else if (en && !ovf)
      integ_d = sum;
  end

  // Integrator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      integ_q <= '0;
    else
      integ_q <= integ_d;
  end

  assign integ = integ_q;

endmodule

// File: rtl/hdng_pid.sv
// Heading-correction PID: heading error -> differential left/right speed commands.
module hdng_pid
  import hdng_pkg::*;
#(
  parameter logic [3:0] P_COEFF        = 4'h3,
  parameter logic [5:0] D_COEFF        = 6'h05,
  parameter int         D_DEPTH        = 2,
  parameter logic [9:0] AT_HDNG_THRESH = 10'd30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        moving,
  input  logic [11:0] dsrd_hdng,
  input  logic [11:0] actl_hdng,
  input  logic        hdng_vld,
  input  logic [10:0] frwrd_spd,
  output logic [11:0] lft_spd,
  output logic [11:0] rght_spd,
  output logic        at_hdng,
  output logic        pid_vld
);

  localparam logic signed [14:0] P_K = 15'(P_COEFF);
  localparam logic signed [14:0] D_K = 15'(D_COEFF);
  localparam logic signed [10:0] TH  = 11'(AT_HDNG_THRESH);

  // Stage-1 state: current error, error from D_DEPTH samples back, history.
  err_t   err_q, err_d;
  err_t   prev_q, prev_d;
  err_t   hist_q [D_DEPTH];
  err_t   hist_d [D_DEPTH];
  logic   v1_q, v1_d;

  // Stage-2 state: registered outputs.
  spd_t   lft_q, lft_d;
  spd_t   rght_q, rght_d;
  logic   at_q, at_d;
  logic   vld_q, vld_d;

  hdng_t  raw;
  err_t   err_sat;
  logic signed [15:0] integ;

  // Heading is circular, so the 12-bit difference is allowed to wrap.
  assign raw     = hdng_t'(actl_hdng - dsrd_hdng);
  assign err_sat = sat10(raw);

  pid_integ u_integ (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~moving),
    .en    (hdng_vld),
    .err   (err_sat),
    .integ (integ)
  );

  // Stage 1: capture error and the oldest history entry, shift history.
  always_comb begin
    err_d  = err_q;
    prev_d = prev_q;
    hist_d = hist_q;
    v1_d   = hdng_vld;
    if (hdng_vld) begin
      err_d     = err_sat;
      prev_d    = hist_q[D_DEPTH-1];
      hist_d[0] = err_sat;
      for (int i = 1; i < D_DEPTH; i++)
        hist_d[i] = hist_q[i-1];
    end
  end

  // Stage-1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= '0;
      prev_q <= '0;
      v1_q   <= 1'b0;
      for (int i = 0; i < D_DEPTH; i++)
        hist_q[i] <= '0;
    end else begin
      err_q  <= err_d;
      prev_q <= prev_d;
      v1_q   <= v1_d;
      hist_q <= hist_d;
    end
  end

  // PID terms from registered values, all carried at 15 bits.
  logic signed [14:0] p_term, i_term, d_term, pid;
  logic signed [15:0] i_shift;
  logic signed [10:0] d_raw;
  ddiff_t             d_sat;
  logic signed [14:0] pid_shift;
  logic signed [11:0] pid12;
  logic signed [13:0] fwd_ext, lft_sum, rght_sum;
  logic signed [10:0] err_w;
  logic               in_band;

  assign p_term    = 15'(err_q) * P_K;
  assign i_shift   = integ >>> 4;
  assign i_term    = 15'(i_shift);
  assign d_raw     = 11'(err_q) - 11'(prev_q);
  assign d_sat     = sat7(d_raw);
  assign d_term    = 15'(d_sat) * D_K;
  assign pid       = p_term + i_term + d_term;
  assign pid_shift = pid >>> 3;
  assign pid12     = 12'(pid_shift);
  assign fwd_ext   = signed'({3'b000, frwrd_spd});
  assign lft_sum   = fwd_ext + 14'(pid12);
  assign rght_sum  = fwd_ext - 14'(pid12);
  assign err_w     = 11'(err_q);
  assign in_band   = (err_w < TH) && (err_w > -TH);

  // Stage 2: update speeds and at_hdng once per stage-1 result, else hold.
  always_comb begin
    lft_d  = lft_q;
    rght_d = rght_q;
    at_d   = at_q;
    vld_d  = v1_q;
    if (v1_q) begin
      at_d = in_band;
      if (moving) begin
        lft_d  = sat12(lft_sum);
        rght_d = sat12(rght_sum);
      end else begin
        lft_d  = '0;
        rght_d = '0;
      end
    end
  end

  // Stage-2 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_q  <= '0;
      rght_q <= '0;
      at_q   <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      lft_q  <= lft_d;
      rght_q <= rght_d;
      at_q   <= at_d;
      vld_q  <= vld_d;
    end
  end

  assign lft_spd  = lft_q;
  assign rght_spd = rght_q;
  assign at_hdng  = at_q;
  assign pid_vld  = vld_q;

endmodule

// File: tb/tb_hdng_pid.sv
// Bench for hdng_pid: directed steps plus random traffic against a scoreboard model.
module tb_hdng_pid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        moving = 1'b0;
  logic        hdng_vld = 1'b0;
  logic [11:0] dsrd_hdng = '0;
  logic [11:0] actl_hdng = '0;
  logic [10:0] frwrd_spd = '0;
  logic [11:0] lft_spd, rght_spd;
  logic        at_hdng, pid_vld;

  hdng_pid dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .moving    (moving),
    .dsrd_hdng (dsrd_hdng),
    .actl_hdng (actl_hdng),
    .hdng_vld  (hdng_vld),
    .frwrd_spd (frwrd_spd),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .at_hdng   (at_hdng),
    .pid_vld   (pid_vld)
  );

  always #5 clk = ~clk;

  localparam int DD = 2;

  typedef struct {
    int pid12;
    int at;
    int due;
  } exp_t;

  exp_t pend[$];
  int   hist[$];
  int   integ_m = 0;
  int   last_l = 0, last_r = 0, last_at = 0;
  int   cyc = 0;
  int   total = 0, bad = 0;

  function automatic int sat(int x, int lo, int hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, update the model, then check what is due.
  task automatic step(bit vld, int d, int a, int f, bit mv);
    exp_t e;
    int raw, err, prev, s, pid, el, er;
    dsrd_hdng = 12'(d);
    actl_hdng = 12'(a);
    frwrd_spd = 11'(f);
    moving    = mv;
    hdng_vld  = vld;
    if (!mv) integ_m = 0;
    if (vld) begin
      raw = (a - d) & 32'hFFF;
      if (raw >= 2048) raw -= 4096;
      err  = sat(raw, -512, 511);
      prev = (hist.size() >= DD) ? hist[hist.size()-DD] : 0;
      hist.push_back(err);
      if (mv) begin
        s = integ_m + err;
        if (s <= 32767 && s >= -32768) integ_m = s;
      end
      pid     = err * 3 + (integ_m >>> 4) + sat(err - prev, -64, 63) * 5;
      e.pid12 = pid >>> 3;
      e.at    = (err < 30 && err > -30) ? 1 : 0;
      e.due   = cyc + 2;
      pend.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e  = pend.pop_front();
      el = mv ? sat(f + e.pid12, -2048, 2047) : 0;
      er = mv ? sat(f - e.pid12, -2048, 2047) : 0;
      chk("pid_vld", pid_vld, 1);
      chk("lft_spd", $signed(lft_spd), el);
      chk("rght_spd", $signed(rght_spd), er);
      chk("at_hdng", at_hdng, e.at);
      last_l = el; last_r = er; last_at = e.at;
      $display("txn cyc=%0d lft=%0d rght=%0d at=%0d", cyc, $signed(lft_spd), $signed(rght_spd), at_hdng);
    end else begin
      chk("pid_vld_idle", pid_vld, 0);
      chk("lft_hold", $signed(lft_spd), last_l);
      chk("rght_hold", $signed(rght_spd), last_r);
      chk("at_hold", at_hdng, last_at);
    end
  endtask

  // Async reset asserted mid-cycle, one cycle after a hdng_vld pulse.
  task automatic mid_reset();
    hdng_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    pend.delete();
    hist.delete();
    integ_m = 0;
    last_l = 0; last_r = 0; last_at = 0;
    chk("rst_lft", $signed(lft_spd), 0);
    chk("rst_rght", $signed(rght_spd), 0);
    chk("rst_at", at_hdng, 0);
    chk("rst_vld", pid_vld, 0);
    @(posedge clk);
    #1;
    cyc++;
    chk("rst_no_vld", pid_vld, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    chk("post_rst_vld", pid_vld, 0);
  endtask

  initial begin
    int d, a, f;
    bit v, mv;

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_lft", $signed(lft_spd), 0);
    chk("reset_rght", $signed(rght_spd), 0);
    chk("reset_at", at_hdng, 0);
    chk("reset_vld", pid_vld, 0);
    rst_n = 1'b1;

    // Basic single sample: P=192 I=4 D=315 -> 575 / 449.
    step(1, 12'h000, 12'h040, 12'h200 & 11'h7FF, 1);
    step(0, 12'h000, 12'h040, 12'h200, 1);
    step(0, 12'h000, 12'h040, 12'h200, 1);
    chk("t1_lft", $signed(lft_spd), 575);
    chk("t1_rght", $signed(rght_spd), 449);
    chk("t1_at", at_hdng, 0);

    // Circular wrap: 0x800 - 0x7FF is +1.
    step(1, 12'h7FF, 12'h800, 12'h200, 1);
    step(0, 12'h7FF, 12'h800, 12'h200, 1);
    step(0, 12'h7FF, 12'h800, 12'h200, 1);
    chk("t2_at", at_hdng, 1);

    // Error saturation and integrator overflow hold.
    for (int i = 0; i < 70; i++)
      step(1, 12'h000, 12'h7FF, 12'h100, 1);
    repeat (3) step(0, 12'h000, 12'h7FF, 12'h100, 1);

    // Moving low clears integrator; moving low at stage 2 zeroes speeds.
    step(0, 12'h000, 12'h010, 12'h300, 0);
    step(1, 12'h000, 12'h010, 12'h300, 1);
    step(0, 12'h000, 12'h010, 12'h300, 1);
    step(1, 12'h000, 12'h050, 12'h300, 1);
    step(0, 12'h000, 12'h050, 12'h300, 0);
    step(1, 12'h000, 12'h050, 12'h300, 0);
    step(0, 12'h000, 12'h050, 12'h300, 0);
    step(0, 12'h000, 12'h050, 12'h300, 1);

    // Reset one cycle after a pulse drops the pending result.
    step(1, 12'h000, 12'h100, 12'h200, 1);
    mid_reset();

    // Back-to-back errors 10, 20, 30 from a clean history.
    step(1, 100, 110, 12'h200, 1);
    step(1, 100, 120, 12'h200, 1);
    step(1, 100, 130, 12'h200, 1);
    repeat (3) step(0, 100, 130, 12'h200, 1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      v  = ($urandom_range(0, 1) == 1);
      d  = int'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) == 0)
        a = int'($urandom_range(0, 4095));
      else
        a = (d + int'($urandom_range(0, 120)) - 60) & 32'hFFF;
      f  = int'($urandom_range(0, 2047));
      mv = ($urandom_range(0, 9) != 0);
      step(v, d, a, f, mv);
    end
    repeat (3) step(0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
